// File: rtl/seq_nibble_compare.sv
// Sequential magnitude comparator: walks two WIDTH-bit operands one nibble per clock, LSB first,
// folding each nibble into a one-hot {gt,lt,eq} cascade. Define SEQ_CMP_SIGNED_EN for two's complement operands.
module seq_nibble_compare #(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iCascade,
    output logic             oBusy,
    output logic             oDone,
    output logic [2:0]       oResult,
    output logic [1:0]       oDbgState
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIB - 1);

    localparam logic [2:0] CASC_GT = 3'b100;
    localparam logic [2:0] CASC_LT = 3'b010;
    localparam logic [2:0] CASC_EQ = 3'b001;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
            $error("seq_nibble_compare: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    // Handshake: iStart is accepted only while idle (oBusy=0); once accepted the operands and
    // cascade are latched, oBusy stays high through RUN and DONE, and oDone pulses for one cycle
    // with oResult valid from that cycle onward until the next oDone.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_cascade;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       r_result;

    logic [3:0] w_nib_a;
    logic [3:0] w_nib_b;
    logic       w_gt;
    logic       w_lt;

    function automatic logic [2:0] sanitise(input logic [2:0] c);
        case (c)
            CASC_GT, CASC_LT, CASC_EQ: sanitise = c;
            default:                   sanitise = CASC_EQ;
        endcase
    endfunction

    // Operands are shifted right each RUN cycle, so the slice under test is always the low nibble.
    assign w_nib_a = r_a[3:0];
    assign w_nib_b = r_b[3:0];

`ifdef SEQ_CMP_SIGNED_EN
    logic w_top;
    assign w_top = (r_cnt == LAST_NIB);
    assign w_gt  = w_top ? ($signed(w_nib_a) > $signed(w_nib_b)) : (w_nib_a > w_nib_b);
    assign w_lt  = w_top ? ($signed(w_nib_a) < $signed(w_nib_b)) : (w_nib_a < w_nib_b);
`else
    assign w_gt = (w_nib_a > w_nib_b);
    assign w_lt = (w_nib_a < w_nib_b);
`endif

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state   <= ST_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_cascade <= CASC_EQ;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= CASC_EQ;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (iStart) begin
                        r_a       <= iData_a;
                        r_b       <= iData_b;
                        r_cascade <= sanitise(iCascade);
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A higher unequal nibble overrides everything below it; equal passes through.
                    if (w_gt) begin
                        r_cascade <= CASC_GT;
                    end else if (w_lt) begin
                        r_cascade <= CASC_LT;
                    end
                    r_a <= r_a >> 4;
                    r_b <= r_b >> 4;
                    if (r_cnt == LAST_NIB) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done   <= 1'b1;
                    r_result <= r_cascade;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oBusy     = r_busy;
    assign oDone     = r_done;
    assign oResult   = r_result;
    assign oDbgState = r_state;

endmodule

// File: tb/tb_seq_nibble_compare.sv
// Scoreboard bench for seq_nibble_compare: a whole-word compare model predicts each result and
// its oDone cycle; a negedge monitor pops and checks on every oDone pulse.
module tb_seq_nibble_compare;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;
  localparam int LAT   = NIB + 1;

  logic             iClk = 1'b0;
  logic             iRst_n = 1'b0;
  logic             iStart = 1'b0;
  logic [WIDTH-1:0] iData_a = '0;
  logic [WIDTH-1:0] iData_b = '0;
  logic [2:0]       iCascade = 3'b001;
  logic             oBusy;
  logic             oDone;
  logic [2:0]       oResult;
  logic [1:0]       oDbgState;

  seq_nibble_compare #(.WIDTH(WIDTH)) dut (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iStart    (iStart),
    .iData_a   (iData_a),
    .iData_b   (iData_b),
    .iCascade  (iCascade),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult),
    .oDbgState (oDbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 iClk = ~iClk;

  int cyc = 0;
  always @(posedge iClk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2:0] exp_q[$];
  int         lat_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: the nibble cascade is just a full-width compare with the cascade as tie-breaker.
  function automatic logic [2:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                       input logic [2:0] c);
    logic gt;
    logic lt;
`ifdef SEQ_CMP_SIGNED_EN
    gt = $signed(a) > $signed(b);
    lt = $signed(a) < $signed(b);
`else
    gt = a > b;
    lt = a < b;
`endif
    if (gt) return 3'b100;
    if (lt) return 3'b010;
    if (c == 3'b100 || c == 3'b010 || c == 3'b001) return c;
    return 3'b001;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [2:0] last_res;
    logic [2:0] e;
    int         l;
    int         busy_len;
    last_res = 3'b001;
    busy_len = 0;
    forever begin
      @(negedge iClk);
      if (!iRst_n) begin
        last_res = 3'b001;
        busy_len = 0;
      end else begin
        if (oDone) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            l = lat_q.pop_front();
            check("result", 32'(oResult), 32'(e));
            check("done_cycle", 32'(cyc), 32'(l));
            last_res = e;
          end
          check("busy_low_at_done", 32'(oBusy), 32'd0);
        end else begin
          check("result_hold", 32'(oResult), 32'(last_res));
        end
        if (oBusy) begin
          busy_len++;
        end else if (busy_len > 0) begin
          check("busy_len", 32'(busy_len), 32'(LAT));
          busy_len = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (oBusy && n < 50) begin
      @(posedge iClk); #1;
      n++;
    end
    if (oBusy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  // Drives one start pulse; the caller is already at posedge+1 with the DUT idle.
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [2:0] c, input bit expect_done);
    iStart   = 1'b1;
    iData_a  = a;
    iData_b  = b;
    iCascade = c;
    if (expect_done) begin
      exp_q.push_back(model(a, b, c));
      lat_q.push_back(cyc + 1 + LAT);
    end
    @(posedge iClk); #1;
    iStart   = 1'b0;
    iData_a  = $urandom();
    iData_b  = $urandom();
    iCascade = 3'($urandom_range(0, 7));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] c);
    wait_idle();
    start_op(a, b, c, 1'b1);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int               t[3];
    int               n;
    int               k;

    repeat (3) @(posedge iClk);
    #1;
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_done", 32'(oDone), 32'd0);
    check("rst_result", 32'(oResult), 32'h1);
    iRst_n = 1'b1;
    @(posedge iClk); #1;

    // Directed cases
    run_op(16'h1234, 16'h1234, 3'b001);
    run_op(16'h1235, 16'h1234, 3'b001);
    run_op(16'h0FFF, 16'h1000, 3'b001);
    run_op(16'hABCD, 16'hABCD, 3'b100);
    run_op(16'hABCD, 16'hABCD, 3'b011);
    run_op(16'hABCD, 16'hABCD, 3'b010);
    run_op(16'h5555, 16'h5555, 3'b000);
    run_op(16'h5555, 16'h5555, 3'b111);
    run_op(16'h8000, 16'h0001, 3'b001);
    run_op(16'hFFFF, 16'hFFFE, 3'b001);
    run_op(16'h7FFF, 16'h8000, 3'b001);

    // Start during RUN is ignored and not queued
    wait_idle();
    start_op(16'h0001, 16'h0000, 3'b001, 1'b1);
    iStart  = 1'b1;
    iData_a = 16'h0000;
    iData_b = 16'hFFFF;
    @(posedge iClk); #1;
    iStart = 1'b0;
    wait_idle();
    repeat (8) @(posedge iClk);
    #1;

    // Reset mid-operation: no oDone, outputs back to reset values
    start_op(16'h4321, 16'h1234, 3'b001, 1'b0);
    @(posedge iClk); #1;
    @(posedge iClk); #1;
    iRst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(oBusy), 32'd0);
    check("midrst_done", 32'(oDone), 32'd0);
    check("midrst_result", 32'(oResult), 32'h1);
    @(negedge iClk);
    @(posedge iClk); #1;
    iRst_n = 1'b1;
    repeat (8) @(posedge iClk);
    #1;
    check("post_rst_busy", 32'(oBusy), 32'd0);

    // iStart held high: three back-to-back operations, NIB+2 cycles apart
    iStart   = 1'b1;
    iData_a  = 16'h1235;
    iData_b  = 16'h1234;
    iCascade = 3'b001;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(16'h1235, 16'h1234, 3'b001));
      lat_q.push_back(cyc + 1 + LAT + i * (NIB + 2));
    end
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge iClk); #1;
      if (oDone) begin
        t[n] = cyc;
        n++;
        if (n == 3) iStart = 1'b0;
      end
    end
    iStart = 1'b0;
    check("held_done_count", 32'(n), 32'd3);
    if (n == 3) begin
      check("held_spacing_1", 32'(t[1] - t[0]), 32'(NIB + 2));
      check("held_spacing_2", 32'(t[2] - t[1]), 32'(NIB + 2));
    end
    @(posedge iClk); #1;
    wait_idle();

    // Randomized operations with junk start pulses while busy
    for (int i = 0; i < 60; i++) begin
      ra = $urandom();
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(4'($urandom_range(1, 15))) << (4 * $urandom_range(0, NIB - 1)));
        default: rb = $urandom();
      endcase
      repeat ($urandom_range(0, 3)) @(posedge iClk);
      #1;
      wait_idle();
      start_op(ra, rb, 3'($urandom_range(0, 7)), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(1, LAT);
        iStart = 1'b1;
        repeat (k) @(posedge iClk);
        #1;
        iStart = 1'b0;
      end
      wait_idle();
    end

    repeat (10) @(posedge iClk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_nibble_compare.md
Name: seq_nibble_compare

Overview:
- Multi-cycle magnitude comparator for wide operands.
- Compares two WIDTH-bit words one nibble per clock, LSB nibble first.
- Propagates the 3-bit one-hot cascade code {gt,lt,eq} across nibbles: a non-equal higher nibble overrides the result so far; an equal nibble passes the lower result through unchanged.
- Used wherever wide compares must share one small 4-bit compare slice; uses a start/busy/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, derived nibble count; localparam, not overridable.

Ports:
- iClk  in  1  rising-edge clock.
- iRst_n  in  1  asynchronous active-low reset.
- iStart  in  1  start request; sampled only in IDLE.
- iData_a  in  WIDTH  operand A; latched on accepted start.
- iData_b  in  WIDTH  operand B; latched on accepted start.
- iCascade  in  3  initial cascade code {gt,lt,eq}; latched on accepted start.
- oBusy  out  1  high in RUN and DONE.
- oDone  out  1  one-cycle pulse; oResult valid from this cycle.
- oResult  out  3  final code {gt,lt,eq}; always exactly one-hot.

Behaviour:
- Clock and reset: one clock, iClk. Reset is asynchronous and active-low on iRst_n.
- Reset values: state=IDLE, oBusy=0, oDone=0, oResult=3'b001, nibble counter=0.
- States:
  - IDLE: if iStart=1, latch A, B and sanitised iCascade into the internal cascade register; counter=0; go to RUN.
  - RUN: evaluate nibble[counter].
    - A_nib>B_nib: cascade=100.
    - A_nib<B_nib: cascade=010.
    - Equal: cascade unchanged.
    - If counter==NIB-1, go to DONE; else counter+1.
  - DONE: oDone=1, oResult=cascade (registered), go to IDLE.
- Sanitise rule: iCascade not in {100,010,001} (incl. 000, 011, 111) is treated as 001.
- Latency: iStart sampled at edge E0; RUN processes nibbles over edges E1..E_NIB; oDone is high for exactly one cycle after edge E_NIB+1. For WIDTH=16, oDone is seen 5 cycles after start.
- oResult:
  - Updates only on entry to DONE.
  - Holds between operations.
  - Not modified during RUN; it shows the previous result until oDone.
- Nibble compares are unsigned 4-bit unless the optional feature is enabled. No carries between nibbles; ordering comes only from cascade precedence.
- iStart while oBusy=1 (RUN or DONE): ignored, with no queueing. Operands and iCascade may change freely after acceptance.
- iStart high continuously: a new operation is accepted in the IDLE cycle after each DONE, giving a throughput of one compare per NIB+2 cycles.
- Reset asserted mid-operation: immediate return to reset values, with no oDone pulse.

Optional Feature:
- Macro: SEQ_CMP_SIGNED_EN.
- Defined: operands are two's complement. The top nibble (index NIB-1) is compared as signed 4-bit; all lower nibbles stay unsigned.
- Undefined: all nibbles unsigned, and no signed logic is synthesised.
- Latency and handshake are identical in both builds.

Test Plan (WIDTH=16):
- A=0x1234, B=0x1234, iCascade=001 → oDone 5 cycles after start, oResult=001, oBusy high for 5 cycles.
- A=0x1235, B=0x1234 → 100. A=0x0FFF, B=0x1000 → 010 (the top nibble overrides the lower gt results).
- A=B=0xABCD with iCascade=100 → 100. Same operands with iCascade=011 → 001 (sanitised).
- Start A=0x0001, B=0x0000. Pulse iStart with A=0x0000, B=0xFFFF during RUN → ignored, result 100. Then assert iRst_n=0 in the third RUN cycle of a following operation → oBusy=0, oResult=001, no oDone.
- A=0x8000, B=0x0001 → 100 without SEQ_CMP_SIGNED_EN; 010 with it. A=0xFFFF, B=0xFFFE → 100 in both builds.
- iStart held high for 3 operations → oDone pulses spaced exactly 6 cycles apart.
